// File: rtl/jt49_echo.sv
// ---------------------------------------------------------------------------
// jt49_echo
//   Feedback comb (echo) stage for the JT49 filter chain. Every accepted
//   sample is added to an attenuated copy of the output produced `len`
//   samples earlier, saturated to all-ones, written back into a circular
//   RAM and presented on `dout`. After reset an internal sequencer zeroes
//   the whole RAM before the first sample is accepted.
//
// Parameters
//   DW     sample width (unsigned data)
//   depth  RAM address width; the RAM holds 2**depth samples
//
// Ports
//   clk      in   system clock
//   rst      in   asynchronous, active-high reset
//   cen      in   sample strobe (one-cycle pulse, >= 4 clk apart)
//   din      in   input sample, taken on the clk edge where cen=1
//   len      in   echo delay in samples; 0 disables feedback
//   fb_sh    in   feedback attenuation, gain = 2^-(fb_sh+1)
//   dout     out  last processed sample, held between updates
//   dout_ok  out  one-cycle strobe, high in the cycle dout has updated
//   busy     out  high while the RAM clear is running
// ---------------------------------------------------------------------------
module jt49_echo #(
    parameter int DW    = 8,
    parameter int depth = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic [DW-1:0]    din,
    input  logic [depth-1:0] len,
    input  logic [2:0]       fb_sh,
    output logic [DW-1:0]    dout,
    output logic             dout_ok,
    output logic             busy
);

    localparam int RAM_SIZE = 1 << depth;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        READ,
        SUM
    } state_t;

    state_t state, state_d;

    logic [depth-1:0] clr_cnt;
    logic [depth-1:0] wrpos;
    logic [depth-1:0] rdpos;
    logic [DW-1:0]    din_l;
    logic [depth-1:0] len_l;
    logic [2:0]       fb_sh_l;
    logic [DW-1:0]    dly;

    logic [DW-1:0]    ram [0:RAM_SIZE-1];
    logic [DW-1:0]    ram_q;
    logic             ram_we;
    logic [depth-1:0] ram_wa;
    logic [DW-1:0]    ram_wd;

    logic             accept;
    logic             clr_last;
    logic [DW-1:0]    fb;
    logic [DW:0]      sum;
    logic [DW-1:0]    res;

    // Read address wraps modulo the RAM size by plain depth-bit subtraction.
    assign rdpos    = wrpos - len;
    assign clr_last = (clr_cnt == {depth{1'b1}});
    assign busy     = (state == CLEAR);

    // Feedback path: len_l=0 means no echo at all, not "echo of the
    // sample being written right now".
    assign fb  = (len_l == '0) ? '0 : DW'(dly >> ({1'b0, fb_sh_l} + 4'd1));
    assign sum = {1'b0, din_l} + {1'b0, fb};
    assign res = sum[DW] ? {DW{1'b1}} : sum[DW-1:0];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge value of its neighbours, regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= CLEAR;
        else     state <= state_d;
    end

    // ------------------------------------------------------------------
    // Next state and RAM write control
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path through the
        // case can leave it unassigned and infer a latch.
        state_d = state;
        accept  = 1'b0;
        ram_we  = 1'b0;
        ram_wa  = wrpos;
        ram_wd  = res;
        case (state)
            CLEAR: begin
                ram_we = 1'b1;
                ram_wa = clr_cnt;
                ram_wd = '0;
                if (clr_last) state_d = IDLE;
            end
            IDLE: begin
                if (cen) begin
                    accept  = 1'b1;
                    state_d = READ;
                end
            end
            READ: begin
                state_d = SUM;
            end
            SUM: begin
                ram_we  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = CLEAR;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_cnt <= '0;
            wrpos   <= '0;
            din_l   <= '0;
            len_l   <= '0;
            fb_sh_l <= '0;
            dly     <= '0;
            dout    <= '0;
            dout_ok <= 1'b0;
        end else begin
            dout_ok <= 1'b0;
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_last) wrpos <= '0;
                end
                IDLE: begin
                    if (accept) begin
                        din_l   <= din;
                        len_l   <= len;
                        fb_sh_l <= fb_sh;
                    end
                end
                READ: begin
                    dly <= ram_q;
                end
                SUM: begin
                    dout    <= res;
                    dout_ok <= 1'b1;
                    wrpos   <= wrpos + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Circular sample RAM: one write port, registered read
    // ------------------------------------------------------------------
    // NOTE: the array and its read register have no reset; the CLEAR walk
    // zeroes the contents and dly is only loaded after a real read.
    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_wa] <= ram_wd;
        if (accept) ram_q <= ram[rdpos];
    end

endmodule

// File: tb/tb_jt49_echo.sv
// ---------------------------------------------------------------------------
// tb_jt49_echo
//   Directed bench for jt49_echo with depth=4. The stimulus side pushes the
//   expected output value and the cycle it must appear in; an independent
//   monitor pops and compares on every dout_ok.
// ---------------------------------------------------------------------------
module tb_jt49_echo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst;
    logic             cen;
    logic [DW-1:0]    din;
    logic [DEPTH-1:0] len;
    logic [2:0]       fb_sh;
    logic [DW-1:0]    dout;
    logic             dout_ok;
    logic             busy;

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_checks;
    int   n_fail;

    jt49_echo #(.DW(DW), .depth(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .cen     (cen),
        .din     (din),
        .len     (len),
        .fb_sh   (fb_sh),
        .dout    (dout),
        .dout_ok (dout_ok),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Monitor: every dout_ok must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && dout_ok) begin
            if (sb.size() == 0) begin
                check("unexpected dout_ok", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("dout", int'(dout), e.val);
                check("dout_ok cycle", cyc, e.cyc);
            end
        end
    end

    // One accepted sample with its hand-computed result; cen spacing is 4.
    task automatic send(input int d, input int l, input int sh, input int e);
        exp_t x;
        @(posedge clk); #1;
        din   = DW'(d);
        len   = DEPTH'(l);
        fb_sh = 3'(sh);
        cen   = 1'b1;
        x.val = e;
        x.cyc = cyc + 3;
        sb.push_back(x);
        @(posedge clk); #1;
        cen = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    // Reset, then measure the clear time; a cen during busy must be dropped.
    task automatic do_reset();
        int n;
        @(posedge clk); #1;
        rst = 1'b1;
        cen = 1'b0;
        #1;
        check("busy in reset", int'(busy), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            cen = (n == 5);
            @(posedge clk); #1;
            n++;
            if (n == 8) check("dout during clear", int'(dout), 0);
        end
        cen = 1'b0;
        check("busy length", n, 1 << DEPTH);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        check("scoreboard drained", sb.size(), 0);
    endtask

    int byp[8] = '{0, 255, 1, 128, 77, 200, 3, 254};
    int imp[13] = '{100, 0, 0, 50, 0, 0, 25, 0, 0, 12, 0, 0, 6};

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst   = 1'b1;
        cen   = 1'b0;
        din   = '0;
        len   = '0;
        fb_sh = '0;
        #3;
        check("reset dout", int'(dout), 0);
        check("reset dout_ok", int'(dout_ok), 0);
        check("reset busy", int'(busy), 1);
        #20;

        // Reset clear timing
        do_reset();

        // Impulse echo: len=3, gain 1/2
        for (int i = 0; i < 13; i++) send((i == 0) ? 100 : 0, 3, 0, imp[i]);
        drain();

        // Bypass with len=0, plus a cen that lands in READ and must be dropped
        for (int i = 0; i < 8; i++) send(byp[i], 0, 5, byp[i]);
        @(posedge clk); #1;
        din = 8'd9; len = '0; cen = 1'b1;
        begin
            exp_t x;
            x.val = 9;
            x.cyc = cyc + 3;
            sb.push_back(x);
        end
        @(posedge clk); #1;
        din = 8'd99;
        @(posedge clk); #1;
        cen = 1'b0;
        repeat (4) @(posedge clk);
        drain();

        // Saturation: len=1, 200 + 100 clips to 255
        do_reset();
        send(200, 1, 0, 200);
        send(200, 1, 0, 255);
        send(200, 1, 0, 255);
        send(200, 1, 0, 255);
        drain();

        // Reset mid-sample: assert rst while the DUT is in READ
        @(posedge clk); #1;
        din = 8'd77; cen = 1'b1;
        @(posedge clk); #1;
        cen = 1'b0;
        rst = 1'b1;
        #1;
        check("mid-reset dout", int'(dout), 0);
        check("mid-reset dout_ok", int'(dout_ok), 0);
        check("mid-reset busy", int'(busy), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        begin
            int n;
            n = 0;
            while (busy && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            check("busy length after mid-reset", n, 1 << DEPTH);
        end
        for (int i = 0; i < 7; i++) send((i == 0) ? 100 : 0, 3, 0, imp[i]);
        drain();

        // Pointer wrap (len=15, gain 1/8), then len switched to 2
        do_reset();
        send(128, 15, 2, 128);
        for (int i = 1; i < 15; i++) send(0, 15, 2, 0);
        send(0, 15, 2, 16);
        send(0, 2, 2, 0);
        send(0, 2, 2, 2);
        send(0, 2, 2, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
